// File: rtl/wave_pkg.sv
// Shared types and constants for the waveform-to-I2S transmit path.
package wave_pkg;
    localparam int SAMPLE_W   = 16;
    localparam int SLOTS      = 32;
    localparam int SLOT_W     = $clog2(SLOTS);
    localparam int BIT_IDX_W  = $clog2(SAMPLE_W);
    localparam int UNDERRUN_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [SLOT_W-1:0]          slot_t;

    // Word bit carried by slots 1..31: (16 - slot) mod 16 gives 15..0 for each half-frame.
    function automatic logic [BIT_IDX_W-1:0] slot_bit_idx(input slot_t slot);
        return BIT_IDX_W'(SLOT_W'(SAMPLE_W) - slot);
    endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles bclk_o every CLK_DIV clk cycles and flags the cycle whose edge makes it fall.
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic bclk_o,
    output logic fall_o
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == CNT_MAX);
        div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // Strobe is high in the cycle before the fall so slot state updates with the same edge.
    assign fall_o = wrap & bclk_q;
endmodule

// File: rtl/wave_i2s_tx.sv
// Mono sample -> stereo I2S serialiser with one-word hold buffer and underrun counter.
// Optional WAVE_I2S_MUTE_EN adds mute_i, which zeroes the word loaded at frame start.
module wave_i2s_tx
    import wave_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef WAVE_I2S_MUTE_EN
    input  logic                  mute_i,
`endif
    input  sample_t               s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  frame_start_o,
    output logic [UNDERRUN_W-1:0] underrun_cnt_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o
);
    logic fall;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk_gen (
        .clk    (clk),
        .rst    (rst),
        .bclk_o (bclk_o),
        .fall_o (fall)
    );

    slot_t                 slot_q, slot_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic                  frame_start_q, frame_start_d;
    logic [UNDERRUN_W-1:0] underrun_q, underrun_d;
    sample_t               hold_word_q, hold_word_d;
    logic                  hold_full_q, hold_full_d;
    sample_t               cur_word_q, cur_word_d;
    logic                  accept;

    always_comb begin
        accept        = s_valid & ~hold_full_q;
        slot_d        = slot_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = underrun_q;
        hold_word_d   = hold_word_q;
        hold_full_d   = hold_full_q;
        cur_word_d    = cur_word_q;

        if (accept) begin
            hold_word_d = s_data;
            hold_full_d = 1'b1;
        end

        if (fall) begin
            slot_d  = slot_q + SLOT_W'(1);
            lrclk_d = slot_d[SLOT_W-1];
            if (slot_d == '0) begin
                frame_start_d = 1'b1;
                // The outgoing word becomes the previous word; only its LSB is ever sent (slot 0).
                sdata_d = cur_word_q[0];
                if (hold_full_q) begin
                    cur_word_d  = hold_word_q;
                    hold_full_d = 1'b0;
                end else if (underrun_q != '1) begin
                    underrun_d = underrun_q + UNDERRUN_W'(1);
                end
`ifdef WAVE_I2S_MUTE_EN
                if (mute_i) begin
                    cur_word_d = '0;
                end
`endif
            end else begin
                sdata_d = cur_word_q[slot_bit_idx(slot_d)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '1;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= '0;
            hold_word_q   <= '0;
            hold_full_q   <= 1'b0;
            cur_word_q    <= '0;
        end else begin
            slot_q        <= slot_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            hold_word_q   <= hold_word_d;
            hold_full_q   <= hold_full_d;
            cur_word_q    <= cur_word_d;
        end
    end

    assign s_ready        = ~hold_full_q;
    assign frame_start_o  = frame_start_q;
    assign underrun_cnt_o = underrun_q;
    assign lrclk_o        = lrclk_q;
    assign sdata_o        = sdata_q;
endmodule

// File: tb/tb_wave_i2s_tx.sv
// Directed bench for wave_i2s_tx: CLK_DIV=4 instance for most cases, CLK_DIV=1 instance for fast BCLK.
module tb_wave_i2s_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_ready, frame_start, bclk, lrclk, sdata;
    logic [15:0] s_data, underrun;
    logic        rst1, s_valid1, s_ready1, frame_start1, bclk1, lrclk1, sdata1;
    logic [15:0] s_data1, underrun1;
`ifdef WAVE_I2S_MUTE_EN
    logic        mute, mute1;
`endif

    wave_i2s_tx #(.CLK_DIV(4)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef WAVE_I2S_MUTE_EN
        .mute_i         (mute),
`endif
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .frame_start_o  (frame_start),
        .underrun_cnt_o (underrun),
        .bclk_o         (bclk),
        .lrclk_o        (lrclk),
        .sdata_o        (sdata)
    );

    wave_i2s_tx #(.CLK_DIV(1)) dut1 (
        .clk            (clk),
        .rst            (rst1),
`ifdef WAVE_I2S_MUTE_EN
        .mute_i         (mute1),
`endif
        .s_data         (s_data1),
        .s_valid        (s_valid1),
        .s_ready        (s_ready1),
        .frame_start_o  (frame_start1),
        .underrun_cnt_o (underrun1),
        .bclk_o         (bclk1),
        .lrclk_o        (lrclk1),
        .sdata_o        (sdata1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_bclk"},     32'(bclk),        32'd0);
        check({pfx, "_lrclk"},    32'(lrclk),       32'd1);
        check({pfx, "_sdata"},    32'(sdata),       32'd0);
        check({pfx, "_s_ready"},  32'(s_ready),     32'd1);
        check({pfx, "_fs"},       32'(frame_start), 32'd0);
        check({pfx, "_underrun"}, 32'(underrun),    32'd0);
    endtask

    logic [15:0] pat;

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        rst1 = 1'b1; s_valid1 = 1'b0; s_data1 = '0;
`ifdef WAVE_I2S_MUTE_EN
        mute = 1'b0; mute1 = 1'b0;
`endif
        // Test 1: 0xA5C3 valid from reset, frame start at clk 8, MSB-first with one-BCLK delay.
        run(3);
        check_reset("t1_rst");
        s_valid = 1'b1; s_data = 16'hA5C3; rst = 1'b0;
        run(4);
        check("t1_bclk_first_rise", 32'(bclk), 32'd1);
        run(3);
        check("t1_fs_clk7", 32'(frame_start), 32'd0);
        run(1);
        check("t1_fs_clk8", 32'(frame_start), 32'd1);
        check("t1_bclk_clk8", 32'(bclk), 32'd0);
        check("t1_lrclk_slot0", 32'(lrclk), 32'd0);
        check("t1_sdata_slot0", 32'(sdata), 32'd0);
        check("t1_s_ready_clk8", 32'(s_ready), 32'd1);
        pat = 16'b1010_0101_1100_0011;
        for (int k = 1; k <= 16; k++) begin
            run(8);
            check($sformatf("t1_sdata_slot%0d", k), 32'(sdata), 32'(pat[16-k]));
            check($sformatf("t1_lrclk_slot%0d", k), 32'(lrclk), (k == 16) ? 32'd1 : 32'd0);
        end
        run(8);
        check("t1_sdata_slot17_msb", 32'(sdata), 32'd1);
        run(120);
        check("t1_fs_frame2", 32'(frame_start), 32'd1);
        check("t1_sdata_prev_lsb", 32'(sdata), 32'd1);
        check("t1_underrun_frame2", 32'(underrun), 32'd0);

        // Test 2: one word 0x8000, then no data for three frames.
        rst = 1'b1;
        run(1);
        s_valid = 1'b1; s_data = 16'h8000; rst = 1'b0;
        run(1);
        s_valid = 1'b0; s_data = 16'hFFFF;
        check("t2_s_ready_after_accept", 32'(s_ready), 32'd0);
        run(7);
        check("t2_fs_frame0", 32'(frame_start), 32'd1);
        check("t2_underrun_frame0", 32'(underrun), 32'd0);
        run(8);
        check("t2_sdata_f0_slot1", 32'(sdata), 32'd1);
        run(8);
        check("t2_sdata_f0_slot2", 32'(sdata), 32'd0);
        for (int f = 1; f <= 3; f++) begin
            run(240);
            check($sformatf("t2_fs_frame%0d", f), 32'(frame_start), 32'd1);
            check($sformatf("t2_underrun_frame%0d", f), 32'(underrun), 32'(f));
            run(8);
            check($sformatf("t2_sdata_f%0d_slot1", f), 32'(sdata), 32'd1);
            run(8);
            check($sformatf("t2_sdata_f%0d_slot2", f), 32'(sdata), 32'd0);
        end

        // Test 3: back-to-back words; second waits in hold until the next frame start.
        rst = 1'b1;
        run(1);
        s_valid = 1'b1; s_data = 16'h1111; rst = 1'b0;
        run(1);
        check("t3_s_ready_clk1", 32'(s_ready), 32'd0);
        s_data = 16'h2222;
        run(7);
        check("t3_fs_clk8", 32'(frame_start), 32'd1);
        check("t3_s_ready_clk8", 32'(s_ready), 32'd1);
        run(1);
        check("t3_s_ready_clk9", 32'(s_ready), 32'd0);
        s_valid = 1'b0; s_data = 16'hDEAD;
        run(23);
        check("t3_sdata_f0_slot3", 32'(sdata), 32'd0);
        run(8);
        check("t3_sdata_f0_slot4", 32'(sdata), 32'd1);
        run(223);
        check("t3_s_ready_clk263", 32'(s_ready), 32'd0);
        check("t3_fs_clk263", 32'(frame_start), 32'd0);
        run(1);
        check("t3_fs_clk264", 32'(frame_start), 32'd1);
        check("t3_s_ready_clk264", 32'(s_ready), 32'd1);
        check("t3_underrun_clk264", 32'(underrun), 32'd0);
        run(1);
        check("t3_s_ready_clk265", 32'(s_ready), 32'd1);
        run(15);
        check("t3_sdata_f1_slot2", 32'(sdata), 32'd0);
        run(8);
        check("t3_sdata_f1_slot3", 32'(sdata), 32'd1);

        // Test 4: reset at slot 20 discards the held word.
        rst = 1'b1;
        run(1);
        s_valid = 1'b1; s_data = 16'hA5C3; rst = 1'b0;
        run(170);
        check("t4_lrclk_slot20", 32'(lrclk), 32'd1);
        check("t4_s_ready_hold_full", 32'(s_ready), 32'd0);
        rst = 1'b1;
        run(1);
        check_reset("t4_rst");
        rst = 1'b0; s_valid = 1'b0;
        run(7);
        check("t4_fs_clk7", 32'(frame_start), 32'd0);
        run(1);
        check("t4_fs_clk8", 32'(frame_start), 32'd1);
        check("t4_underrun_discarded", 32'(underrun), 32'd1);

        // Test 5: CLK_DIV=1 instance.
        s_valid1 = 1'b1; s_data1 = 16'hA5C3; rst1 = 1'b0;
        run(1);
        check("t5_bclk_clk1", 32'(bclk1), 32'd1);
        check("t5_fs_clk1", 32'(frame_start1), 32'd0);
        run(1);
        check("t5_bclk_clk2", 32'(bclk1), 32'd0);
        check("t5_fs_clk2", 32'(frame_start1), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            run(2);
            check($sformatf("t5_sdata_slot%0d", k), 32'(sdata1), 32'(pat[16-k]));
        end
        run(31);
        check("t5_fs_clk65", 32'(frame_start1), 32'd0);
        run(1);
        check("t5_fs_clk66", 32'(frame_start1), 32'd1);
        check("t5_underrun", 32'(underrun1), 32'd0);

`ifdef WAVE_I2S_MUTE_EN
        // Test 6: mute at frame start zeroes the word but still consumes the hold buffer.
        rst = 1'b1; mute = 1'b1;
        run(1);
        s_valid = 1'b1; s_data = 16'h7FFF; rst = 1'b0;
        run(1);
        s_valid = 1'b0;
        run(7);
        check("t6_fs_clk8", 32'(frame_start), 32'd1);
        check("t6_s_ready_clk8", 32'(s_ready), 32'd1);
        check("t6_underrun_clk8", 32'(underrun), 32'd0);
        for (int k = 1; k <= 31; k++) begin
            run(8);
            check($sformatf("t6_sdata_muted_slot%0d", k), 32'(sdata), 32'd0);
        end
        mute = 1'b0; s_valid = 1'b1; s_data = 16'hC000;
        run(1);
        s_valid = 1'b0;
        run(7);
        check("t6_fs_frame1", 32'(frame_start), 32'd1);
        check("t6_underrun_frame1", 32'(underrun), 32'd0);
        run(8);
        check("t6_sdata_f1_slot1", 32'(sdata), 32'd1);
        run(8);
        check("t6_sdata_f1_slot2", 32'(sdata), 32'd1);
        run(8);
        check("t6_sdata_f1_slot3", 32'(sdata), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
